// File: rtl/lift_scale_ctrl_pkg.sv
// ============================================================================
// lift_pkg : shared constants, state encoding and helpers for lift_scale_ctrl
// Revision : 1.0
// ============================================================================
`default_nettype none

package lift_pkg;

    localparam int NCOEF_S = 6;
    localparam int NCOEF_B = 7;
    localparam int SA_LAT  = 8;

    typedef logic [2:0] state_t;

    localparam logic [2:0] ST_FLUSH = 3'd0;
    localparam logic [2:0] ST_IDLE  = 3'd1;
    localparam logic [2:0] ST_ISSUE = 3'd2;
    localparam logic [2:0] ST_GAP   = 3'd3;
    localparam logic [2:0] ST_DRAIN = 3'd4;
    localparam logic [2:0] ST_DONE  = 3'd5;

    // Coefficient index of the final coefficient in a group for the given mode.
    function automatic logic [2:0] last_coef(input logic big);
        return big ? 3'(NCOEF_B - 1) : 3'(NCOEF_S - 1);
    endfunction

endpackage

`default_nettype wire

// File: rtl/lift_scale_ctrl_if.sv
// ============================================================================
// lift_scale_ctrl_if : requester / scaler side bus of the lift scale controller
// Revision : 1.0
// ============================================================================
`default_nettype none

interface lift_scale_ctrl_if;

    logic       req_s;
    logic [7:0] ngrp_s;
    logic       req_b;
    logic [7:0] ngrp_b;
    logic       gnt_s;
    logic       gnt_b;
    logic       done_s;
    logic       done_b;
    logic       sa_start;
    logic       sa_mode;
    logic       sa_we;
    logic [2:0] sa_wt_addr;
    logic [7:0] rd_grp;
    logic [7:0] wr_grp;
    logic       busy;

    modport master (
        output req_s, ngrp_s, req_b, ngrp_b, sa_we, sa_wt_addr,
        input  gnt_s, gnt_b, done_s, done_b, sa_start, sa_mode,
               rd_grp, wr_grp, busy
    );

    modport slave (
        input  req_s, ngrp_s, req_b, ngrp_b, sa_we, sa_wt_addr,
        output gnt_s, gnt_b, done_s, done_b, sa_start, sa_mode,
               rd_grp, wr_grp, busy
    );

endinterface

`default_nettype wire

// File: rtl/lift_scale_ctrl_rr_arb2.sv
// ============================================================================
// rr_arb2 : two-way round-robin arbiter, index 0 = small, index 1 = big
// Revision : 1.0
// ============================================================================
`default_nettype none

module rr_arb2 (
    input  logic       clk,
    input  logic       rst,
    input  logic [1:0] req_i,
    input  logic       ack_i,
    output logic [1:0] gnt_o
);

    // Index of the requester served most recently; reset value makes small win next.
    logic last_q;
    logic last_d;

    always_comb begin
        gnt_o = req_i;
        if (req_i == 2'b11) begin
            gnt_o = last_q ? 2'b01 : 2'b10;
        end
    end

    always_comb begin
        last_d = last_q;
        if (ack_i && (gnt_o != 2'b00)) begin
            last_d = gnt_o[1];
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            last_q <= 1'b1;
        end else begin
            last_q <= last_d;
        end
    end

endmodule

`default_nettype wire

// File: rtl/lift_scale_ctrl.sv
// ============================================================================
// lift_scale_ctrl : arbitrates small/big lift jobs and sequences the scaler
// Revision : 1.0
// ============================================================================
`default_nettype none

module lift_scale_ctrl
    import lift_pkg::*;
(
    input  logic              clk,
    input  logic              rst,
    lift_scale_ctrl_if.slave  bus
);

    state_t     state_q, state_d;
    logic [2:0] flush_q, flush_d;
    logic [2:0] coef_q,  coef_d;
    logic [7:0] rd_grp_q, rd_grp_d;
    logic [7:0] wr_grp_q, wr_grp_d;
    logic [7:0] ngrp_q,  ngrp_d;
    logic       mode_q,  mode_d;
    logic       busy_q,  busy_d;

    logic [1:0] w_arb_gnt;
    logic       w_we_last;
    logic [7:0] w_wr_grp_nxt;
    logic       w_in_job;

    rr_arb2 u_arb (
        .clk   (clk),
        .rst   (rst),
        .req_i ({bus.req_b, bus.req_s}),
        .ack_i (state_q == ST_IDLE),
        .gnt_o (w_arb_gnt)
    );

    // Scaler write-backs only count while a job owns the scaler; FLUSH swallows stale ones.
    assign w_we_last = bus.sa_we
                    && (bus.sa_wt_addr == last_coef(mode_q))
                    && ((state_q == ST_ISSUE) || (state_q == ST_GAP) || (state_q == ST_DRAIN));
    assign w_wr_grp_nxt = wr_grp_q + {7'd0, w_we_last};

    always_comb begin
        state_d  = state_q;
        flush_d  = flush_q;
        coef_d   = coef_q;
        rd_grp_d = rd_grp_q;
        wr_grp_d = w_wr_grp_nxt;
        ngrp_d   = ngrp_q;
        mode_d   = mode_q;
        case (state_q)
            ST_FLUSH: begin
                if (flush_q == 3'(SA_LAT - 1)) begin
                    state_d = ST_IDLE;
                end else begin
                    flush_d = flush_q + 3'd1;
                end
            end
            ST_IDLE: begin
                if (w_arb_gnt != 2'b00) begin
                    state_d  = ST_ISSUE;
                    mode_d   = w_arb_gnt[1];
                    ngrp_d   = w_arb_gnt[1] ? bus.ngrp_b : bus.ngrp_s;
                    coef_d   = 3'd0;
                    rd_grp_d = 8'd0;
                    wr_grp_d = 8'd0;
                end
            end
            ST_ISSUE: begin
                if (ngrp_q == 8'd0) begin
                    state_d = ST_DONE;
                end else if (coef_q == last_coef(mode_q)) begin
                    coef_d   = 3'd0;
                    rd_grp_d = rd_grp_q + 8'd1;
                    if ((rd_grp_q + 8'd1) == ngrp_q) begin
                        state_d = ST_DRAIN;
                    end else if (!mode_q) begin
                        state_d = ST_GAP;
                    end
                end else begin
                    coef_d = coef_q + 3'd1;
                end
            end
            ST_GAP: begin
                state_d = ST_ISSUE;
            end
            ST_DRAIN: begin
                // Look ahead at this cycle's write so DONE follows the final write immediately.
                if (w_wr_grp_nxt == ngrp_q) begin
                    state_d = ST_DONE;
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_FLUSH;
                flush_d = 3'd0;
            end
        endcase
    end

    // busy mirrors "state != IDLE" one edge ahead, so reset itself still forces it low.
    assign busy_d = (state_d != ST_IDLE);

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= ST_FLUSH;
            flush_q  <= 3'd0;
            coef_q   <= 3'd0;
            rd_grp_q <= 8'd0;
            wr_grp_q <= 8'd0;
            ngrp_q   <= 8'd0;
            mode_q   <= 1'b0;
            busy_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            flush_q  <= flush_d;
            coef_q   <= coef_d;
            rd_grp_q <= rd_grp_d;
            wr_grp_q <= wr_grp_d;
            ngrp_q   <= ngrp_d;
            mode_q   <= mode_d;
            busy_q   <= busy_d;
        end
    end

    assign w_in_job = (state_q == ST_ISSUE) || (state_q == ST_GAP)
                   || (state_q == ST_DRAIN) || (state_q == ST_DONE);

    assign bus.sa_start = (state_q == ST_ISSUE) && (ngrp_q != 8'd0);
    assign bus.sa_mode  = mode_q;
    assign bus.gnt_s    = w_in_job && !mode_q;
    assign bus.gnt_b    = w_in_job &&  mode_q;
    assign bus.done_s   = (state_q == ST_DONE) && !mode_q;
    assign bus.done_b   = (state_q == ST_DONE) &&  mode_q;
    assign bus.rd_grp   = rd_grp_q;
    assign bus.wr_grp   = wr_grp_q;
    assign bus.busy     = busy_q;

endmodule

`default_nettype wire

// File: tb/tb_lift_scale_ctrl.sv
// ============================================================================
// tb_lift_scale_ctrl : self-checking bench with scaler model and timing model
// Revision : 1.0
// ============================================================================
`default_nettype none

module tb_lift_scale_ctrl;
    import lift_pkg::*;

    logic clk;
    logic rst;
    int   checks;
    int   errors;

    lift_scale_ctrl_if bus ();

    lift_scale_ctrl dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Scaler model: each sa_start returns a write SA_LAT cycles later with its coefficient index.
    bit pipe_we   [SA_LAT];
    int pipe_addr [SA_LAT];
    int sc_cnt;

    initial begin
        bus.sa_we      = 1'b0;
        bus.sa_wt_addr = 3'd0;
        sc_cnt         = 0;
        for (int i = 0; i < SA_LAT; i++) begin
            pipe_we[i]   = 1'b0;
            pipe_addr[i] = 0;
        end
        forever begin
            @(negedge clk);
            bus.sa_we      = pipe_we[SA_LAT-1];
            bus.sa_wt_addr = 3'(pipe_addr[SA_LAT-1]);
            for (int i = SA_LAT - 1; i > 0; i--) begin
                pipe_we[i]   = pipe_we[i-1];
                pipe_addr[i] = pipe_addr[i-1];
            end
            pipe_we[0]   = bus.sa_start;
            pipe_addr[0] = sc_cnt;
            if (!(bus.gnt_s || bus.gnt_b)) sc_cnt = 0;
            else if (bus.sa_start) sc_cnt = (sc_cnt + 1) % (bus.sa_mode ? NCOEF_B : NCOEF_S);
        end
    end

    // Timing model, cycles relative to the request cycle (0); grant lands at cycle 1.
    function automatic int ncoef(input bit big);
        return big ? NCOEF_B : NCOEF_S;
    endfunction

    function automatic int period(input bit big);
        return big ? NCOEF_B : NCOEF_S + 1;
    endfunction

    function automatic int last_issue(input bit big, input int k);
        return 1 + k * period(big) + ncoef(big) - 1;
    endfunction

    function automatic bit exp_start(input int rel, input bit big, input int n);
        for (int k = 0; k < n; k++) begin
            if (rel >= 1 + k * period(big) && rel <= last_issue(big, k)) return 1'b1;
        end
        return 1'b0;
    endfunction

    function automatic int exp_done(input bit big, input int n);
        return (n == 0) ? 2 : last_issue(big, n - 1) + SA_LAT + 1;
    endfunction

    function automatic int exp_rd(input int rel, input bit big, input int n);
        int c;
        c = 0;
        for (int k = 0; k < n; k++) if (last_issue(big, k) < rel) c++;
        return c;
    endfunction

    function automatic int exp_wr(input int rel, input bit big, input int n);
        int c;
        c = 0;
        for (int k = 0; k < n; k++) if (last_issue(big, k) + SA_LAT < rel) c++;
        return c;
    endfunction

    task automatic wait_for(input int sel, input int budget, output bit hit);
        hit = 1'b0;
        for (int i = 0; i < budget && !hit; i++) begin
            @(negedge clk);
            case (sel)
                0:       hit = bus.gnt_s || bus.gnt_b;
                1:       hit = bus.done_s;
                default: hit = bus.done_b;
            endcase
        end
    endtask

    // Drives one job from an IDLE cycle and checks every cycle through the following IDLE.
    task automatic run_job(input bit big, input int n, input bit drop_early, input string tag);
        int dr;
        bit in_job;
        bit g_own, g_oth, d_own, d_oth;
        dr = exp_done(big, n);
        if (big) begin bus.req_b = 1'b1; bus.ngrp_b = 8'(n); end
        else     begin bus.req_s = 1'b1; bus.ngrp_s = 8'(n); end
        for (int rel = 1; rel <= dr + 1; rel++) begin
            @(negedge clk);
            in_job = (rel <= dr);
            g_own = big ? bus.gnt_b  : bus.gnt_s;
            g_oth = big ? bus.gnt_s  : bus.gnt_b;
            d_own = big ? bus.done_b : bus.done_s;
            d_oth = big ? bus.done_s : bus.done_b;
            checks += 6;
            if (bus.sa_start !== exp_start(rel, big, n)) begin
                errors++;
                $display("FAIL %s sa_start big=%0b n=%0d rel=%0d got %0b want %0b", tag, big, n, rel, bus.sa_start, exp_start(rel, big, n));
            end
            if (g_own !== in_job) begin
                errors++;
                $display("FAIL %s gnt big=%0b n=%0d rel=%0d got %0b want %0b", tag, big, n, rel, g_own, in_job);
            end
            if (g_oth !== 1'b0) begin
                errors++;
                $display("FAIL %s other_gnt rel=%0d got %0b want 0", tag, rel, g_oth);
            end
            if (d_own !== (rel == dr)) begin
                errors++;
                $display("FAIL %s done big=%0b n=%0d rel=%0d got %0b want %0b", tag, big, n, rel, d_own, rel == dr);
            end
            if (d_oth !== 1'b0) begin
                errors++;
                $display("FAIL %s other_done rel=%0d got %0b want 0", tag, rel, d_oth);
            end
            if (bus.busy !== in_job) begin
                errors++;
                $display("FAIL %s busy rel=%0d got %0b want %0b", tag, rel, bus.busy, in_job);
            end
            if (in_job) begin
                checks += 3;
                if (bus.sa_mode !== big) begin
                    errors++;
                    $display("FAIL %s sa_mode rel=%0d got %0b want %0b", tag, rel, bus.sa_mode, big);
                end
                if (int'(bus.rd_grp) != exp_rd(rel, big, n)) begin
                    errors++;
                    $display("FAIL %s rd_grp rel=%0d got %0d want %0d", tag, rel, bus.rd_grp, exp_rd(rel, big, n));
                end
                if (int'(bus.wr_grp) != exp_wr(rel, big, n)) begin
                    errors++;
                    $display("FAIL %s wr_grp rel=%0d got %0d want %0d", tag, rel, bus.wr_grp, exp_wr(rel, big, n));
                end
            end
            if (rel == 1) begin
                if (big) bus.ngrp_b = 8'($urandom);
                else     bus.ngrp_s = 8'($urandom);
            end
            if (rel == dr || (drop_early && rel == 2)) begin
                if (big) bus.req_b = 1'b0;
                else     bus.req_s = 1'b0;
            end
        end
    endtask

    task automatic test_reset();
        bit exp_busy;
        rst = 1'b1;
        bus.req_s = 1'b0; bus.req_b = 1'b0; bus.ngrp_s = 8'd0; bus.ngrp_b = 8'd0;
        repeat (3) @(negedge clk);
        checks++;
        if ({bus.sa_start, bus.gnt_s, bus.gnt_b, bus.done_s, bus.done_b, bus.busy,
             bus.sa_mode, bus.rd_grp, bus.wr_grp} !== 23'd0) begin
            errors++;
            $display("FAIL reset_outputs got %0h want 0", {bus.sa_start, bus.gnt_s, bus.gnt_b,
                     bus.done_s, bus.done_b, bus.busy, bus.sa_mode, bus.rd_grp, bus.wr_grp});
        end
        bus.req_s = 1'b1;
        rst = 1'b0;
        for (int k = 1; k <= 11; k++) begin
            @(negedge clk);
            exp_busy = (k <= 7) || (k == 9) || (k == 10);
            checks += 3;
            if (bus.busy !== exp_busy) begin
                errors++;
                $display("FAIL flush_busy k=%0d got %0b want %0b", k, bus.busy, exp_busy);
            end
            if (bus.gnt_s !== (k == 9 || k == 10)) begin
                errors++;
                $display("FAIL flush_gnt k=%0d got %0b want %0b", k, bus.gnt_s, k == 9 || k == 10);
            end
            if (bus.done_s !== (k == 10)) begin
                errors++;
                $display("FAIL flush_done k=%0d got %0b want %0b", k, bus.done_s, k == 10);
            end
            if (k == 10) bus.req_s = 1'b0;
        end
    endtask

    task automatic test_small_single();
        run_job(1'b0, 1, 1'b0, "small_1grp");
    endtask

    task automatic test_big_two();
        run_job(1'b1, 2, 1'b0, "big_2grp");
    endtask

    task automatic test_small_two();
        run_job(1'b0, 2, 1'b0, "small_2grp");
    endtask

    task automatic test_zero_groups();
        run_job(1'b1, 0, 1'b0, "big_0grp");
        run_job(1'b0, 0, 1'b0, "small_0grp");
    endtask

    task automatic test_early_release();
        run_job(1'b0, 2, 1'b1, "small_early_drop");
        run_job(1'b1, 3, 1'b1, "big_early_drop");
    endtask

    task automatic test_arbitration();
        bit hit;
        rst = 1'b1;
        bus.req_s = 1'b1; bus.req_b = 1'b1; bus.ngrp_s = 8'd1; bus.ngrp_b = 8'd1;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        for (int r = 0; r < 2; r++) begin
            wait_for(0, 40, hit);
            checks++;
            if (!hit || bus.gnt_s !== 1'b1 || bus.gnt_b !== 1'b0) begin
                errors++;
                $display("FAIL arb_small_first round=%0d got hit=%0b s=%0b b=%0b want s=1 b=0", r, hit, bus.gnt_s, bus.gnt_b);
            end
            wait_for(1, 40, hit);
            checks++;
            if (!hit) begin
                errors++;
                $display("FAIL arb_done_s round=%0d got timeout want done_s", r);
            end
            bus.req_s = 1'b0;
            @(negedge clk);
            checks++;
            if (bus.gnt_s !== 1'b0 || bus.gnt_b !== 1'b0 || bus.busy !== 1'b0) begin
                errors++;
                $display("FAIL arb_idle_between round=%0d got s=%0b b=%0b busy=%0b want 0 0 0", r, bus.gnt_s, bus.gnt_b, bus.busy);
            end
            @(negedge clk);
            checks++;
            if (bus.gnt_b !== 1'b1 || bus.gnt_s !== 1'b0) begin
                errors++;
                $display("FAIL arb_big_second round=%0d got s=%0b b=%0b want s=0 b=1", r, bus.gnt_s, bus.gnt_b);
            end
            wait_for(2, 40, hit);
            checks++;
            if (!hit) begin
                errors++;
                $display("FAIL arb_done_b round=%0d got timeout want done_b", r);
            end
            bus.req_b = 1'b0;
            @(negedge clk);
            if (r == 0) begin
                bus.req_s = 1'b1;
                bus.req_b = 1'b1;
            end
        end
    endtask

    task automatic test_reset_midjob(input int rc);
        bus.req_b = 1'b1;
        bus.ngrp_b = 8'd2;
        for (int rel = 1; rel <= rc; rel++) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        checks++;
        if ({bus.sa_start, bus.gnt_s, bus.gnt_b, bus.done_s, bus.done_b, bus.busy,
             bus.sa_mode, bus.rd_grp, bus.wr_grp} !== 23'd0) begin
            errors++;
            $display("FAIL midrst_outputs rc=%0d got %0h want 0", rc, {bus.sa_start, bus.gnt_s,
                     bus.gnt_b, bus.done_s, bus.done_b, bus.busy, bus.sa_mode, bus.rd_grp, bus.wr_grp});
        end
        for (int k = 2; k <= 8; k++) begin
            @(negedge clk);
            checks += 2;
            if (bus.gnt_b !== 1'b0 || bus.done_b !== 1'b0 || bus.sa_start !== 1'b0) begin
                errors++;
                $display("FAIL midrst_nogrant rc=%0d k=%0d got gnt=%0b done=%0b start=%0b want 0", rc, k, bus.gnt_b, bus.done_b, bus.sa_start);
            end
            if (bus.wr_grp !== 8'd0 || bus.busy !== 1'b1) begin
                errors++;
                $display("FAIL midrst_flush rc=%0d k=%0d got wr_grp=%0d busy=%0b want 0 1", rc, k, bus.wr_grp, bus.busy);
            end
        end
        bus.req_b = 1'b0;
        @(negedge clk);
        checks++;
        if (bus.busy !== 1'b0 || bus.gnt_b !== 1'b0 || bus.done_b !== 1'b0) begin
            errors++;
            $display("FAIL midrst_idle rc=%0d got busy=%0b gnt=%0b done=%0b want 0", rc, bus.busy, bus.gnt_b, bus.done_b);
        end
    endtask

    task automatic test_random();
        for (int j = 0; j < 30; j++) begin
            int gap;
            gap = int'($urandom_range(0, 3));
            repeat (gap) @(negedge clk);
            run_job(bit'($urandom_range(0, 1)), int'($urandom_range(0, 4)),
                    $urandom_range(0, 3) == 0, "random");
        end
    endtask

    initial begin
        checks = 0;
        errors = 0;
        rst    = 1'b1;
        bus.req_s = 1'b0; bus.req_b = 1'b0; bus.ngrp_s = 8'd0; bus.ngrp_b = 8'd0;
        test_reset();
        test_small_single();
        test_big_two();
        test_small_two();
        test_zero_groups();
        test_early_release();
        test_arbitration();
        test_reset_midjob(5);
        test_reset_midjob(9);
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/lift_scale_ctrl.md
LIFT_SCALE_CTRL -- requirements
Module: lift_scale_ctrl

Interface
REQ-001 SHALL have ports: clk in 1 (clock); rst in 1 (reset, synchronous, active-high).
REQ-002 SHALL have req_s in 1: small-lift job request, level, held until done_s.
REQ-003 SHALL have ngrp_s in 8: small-lift group count, sampled at grant.
REQ-004 SHALL have req_b in 1: big-lift job request, level, held until done_b.
REQ-005 SHALL have ngrp_b in 8: big-lift group count, sampled at grant.
REQ-006 SHALL have gnt_s, gnt_b out 1 each: grant, high from first issue cycle through the done cycle.
REQ-007 SHALL have done_s, done_b out 1 each: one-cycle job-complete pulses.
REQ-008 SHALL have sa_start out 1 and sa_mode out 1 (0 small/6 coeff, 1 big/7 coeff) to the scaler.
REQ-009 SHALL have sa_we in 1 and sa_wt_addr in 3: scaler write strobe and write address.
REQ-010 SHALL have rd_grp out 8: group index being read (coefficient RAM base); wr_grp out 8: group index being written.
REQ-011 SHALL have busy out 1: high whenever state is not IDLE.

Function
REQ-012 States SHALL be FLUSH, IDLE, ISSUE, GAP, DRAIN, DONE.
REQ-013 FLUSH SHALL last exactly SA_LAT=8 cycles after reset; no grant is given and sa_we is ignored.
REQ-014 IDLE SHALL grant on a registered request; req seen at cycle 0 -> ISSUE with gnt and sa_start high at cycle 1.
REQ-015 Both requests pending SHALL be arbitrated round-robin; first arbitration after reset favours small.
REQ-016 sa_mode SHALL be latched at grant and held constant until IDLE.
REQ-017 ISSUE SHALL hold sa_start high for NCOEF cycles per group (6 small, 7 big); rd_grp increments after the last coefficient of each group.
REQ-018 Small mode SHALL insert one GAP cycle (sa_start=0) between groups; big mode SHALL issue groups back-to-back.
REQ-019 After the last group, DRAIN SHALL wait until the write-side group count equals ngrp.
REQ-020 Each sa_we with sa_wt_addr==NCOEF-1 SHALL increment wr_grp; sa_we SHALL be counted only in ISSUE, GAP and DRAIN.
REQ-021 DONE SHALL last one cycle, pulse the matching done, then go to IDLE with gnt low.
REQ-022 ngrp==0 SHALL go from grant directly to DONE with no sa_start cycle.
REQ-023 A request deasserted mid-job SHALL NOT abort the job.
REQ-024 A request pending at DONE SHALL wait for the IDLE re-arbitration.

Reset
REQ-025 rst SHALL force FLUSH and clear the flush counter.
REQ-026 rst SHALL drive sa_start, gnt_*, done_*, busy, sa_mode, rd_grp and wr_grp to 0.
REQ-027 rst SHALL make the round-robin pointer favour small next.
REQ-028 rst mid-job SHALL abandon the job without a done pulse; in-flight sa_we pulses SHALL be absorbed by FLUSH.

Structure
REQ-029 Shared package lift_pkg SHALL hold NCOEF_S=6, NCOEF_B=7, SA_LAT=8 and the state enum.
REQ-030 One sub-module rr_arb2 (two-way round-robin arbiter with registered last-served pointer) SHALL be used.
REQ-031 Implementation SHALL be roughly 150-300 lines.

Verification
REQ-032 req_s, ngrp_s=1 at cycle 0:
- sa_start high cycles 1-6;
- modelled sa_we at cycles 9-14;
- done_s at cycle 15.
REQ-033 req_b, ngrp_b=2:
- sa_start high cycles 1-14 continuously;
- rd_grp 0->1 at cycle 8;
- done_b at cycle 23.
REQ-034 req_s, ngrp_s=2:
- sa_start low only at cycle 7;
- done_s at cycle 22.
REQ-035 req_s and req_b asserted together from reset release:
- small job first, then big;
- with both re-asserted, next order is small, big.
REQ-036 rst at cycle 5 of a big job:
- all outputs 0 next cycle;
- no grant for 8 cycles;
- no done pulse.
REQ-037 ngrp_b=0:
- done_b 2 cycles after request;
- sa_start never asserted.
